// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control slice.
// Holds the FSM state encoding, the default slot count and the slot index
// width that the counter datapath also uses.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } sw_state_e;

  localparam int NUM_SLOTS_DEF = 3;
  localparam int SLOT_W        = 2;

endpackage

// File: rtl/btn_sync_edge.sv
// Button synchronizer plus rising-edge pulse generator.
// Ports:
//   clk     - system clock
//   reset   - synchronous, active-high
//   btn_i   - debounced, asynchronous button level
//   pulse_o - one-cycle pulse on a rising edge of the synchronized level
// The chain and the edge-history flop reset to 1, so a button that is already
// held when reset releases is treated as "already pressed" and makes no pulse.
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2  // must be at least 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic pulse_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Combinational pulse; the consumer registers whatever it does with it,
  // which puts the visible effect SYNC_STAGES edges after first sampling.
  assign pulse_o = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch button sequencer.
// Turns five debounced button levels into control strobes for the counter
// datapath and tracks which time-memory slots hold a saved value.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   btn_run/clr/save/load/slot - debounced button levels
//   start             - counter run enable (high exactly in RUN)
//   cnt_reset         - one-cycle counter clear
//   save_time_signal  - one-cycle save strobe
//   load_time_signal  - one-cycle load strobe
//   slot              - current slot index
//   slot_valid        - bit i set once slot i has been saved
//   state             - FSM state (IDLE=00, RUN=01, PAUSE=10)
//
// state | meaning
// IDLE  | counter cleared / stopped, waiting for run or a load
// RUN   | counter running; save captures a lap
// PAUSE | counter held; save and load both allowed
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int NUM_SLOTS   = NUM_SLOTS_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 btn_run,
  input  logic                 btn_clr,
  input  logic                 btn_save,
  input  logic                 btn_load,
  input  logic                 btn_slot,
  output logic                 start,
  output logic                 cnt_reset,
  output logic                 save_time_signal,
  output logic                 load_time_signal,
  output logic [SLOT_W-1:0]    slot,
  output logic [NUM_SLOTS-1:0] slot_valid,
  output logic [1:0]           state
);

  logic ev_run, ev_clr, ev_save, ev_load, ev_slot;

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_run  (.clk(clk), .reset(reset), .btn_i(btn_run),  .pulse_o(ev_run));
  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clr  (.clk(clk), .reset(reset), .btn_i(btn_clr),  .pulse_o(ev_clr));
  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_save (.clk(clk), .reset(reset), .btn_i(btn_save), .pulse_o(ev_save));
  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_load (.clk(clk), .reset(reset), .btn_i(btn_load), .pulse_o(ev_load));
  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_slot (.clk(clk), .reset(reset), .btn_i(btn_slot), .pulse_o(ev_slot));

  sw_state_e             state_q;
  logic [SLOT_W-1:0]     slot_q;
  logic [SLOT_W-1:0]     slot_d;
  logic [NUM_SLOTS-1:0]  valid_q;
  logic [NUM_SLOTS-1:0]  slot_mask;
  logic                  load_ok;

  // One-hot of the current (pre-update) slot; save and load act on it even
  // when the slot button fires in the same cycle.
  always_comb begin
    slot_mask = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slot_mask[i] = (slot_q == SLOT_W'(i));
    end
  end

  assign load_ok = |(valid_q & slot_mask);
  assign slot_d  = (slot_q == SLOT_W'(NUM_SLOTS - 1)) ? '0 : slot_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      start            <= 1'b0;
      cnt_reset        <= 1'b0;
      save_time_signal <= 1'b0;
      load_time_signal <= 1'b0;
      slot_q           <= '0;
      valid_q          <= '0;
    end else begin
      cnt_reset        <= 1'b0;
      save_time_signal <= 1'b0;
      load_time_signal <= 1'b0;

      if (ev_slot) slot_q <= slot_d;

      // Priority clr > run > save > load: the first event present wins and
      // the rest are dropped, even when the winner is ignored in this state.
      unique case (state_q)
        ST_IDLE: begin
          if (ev_clr) begin
            cnt_reset <= 1'b1;
          end else if (ev_run) begin
            state_q <= ST_RUN;
            start   <= 1'b1;
          end else if (ev_save) begin
            // nothing to capture while idle
          end else if (ev_load && load_ok) begin
            state_q          <= ST_PAUSE;
            load_time_signal <= 1'b1;
          end
        end
        ST_RUN: begin
          if (ev_clr) begin
            state_q   <= ST_IDLE;
            start     <= 1'b0;
            cnt_reset <= 1'b1;
          end else if (ev_run) begin
            state_q <= ST_PAUSE;
            start   <= 1'b0;
          end else if (ev_save) begin
            save_time_signal <= 1'b1;
            valid_q          <= valid_q | slot_mask;
          end
        end
        ST_PAUSE: begin
          if (ev_clr) begin
            state_q   <= ST_IDLE;
            cnt_reset <= 1'b1;
          end else if (ev_run) begin
            state_q <= ST_RUN;
            start   <= 1'b1;
          end else if (ev_save) begin
            save_time_signal <= 1'b1;
            valid_q          <= valid_q | slot_mask;
          end else if (ev_load && load_ok) begin
            load_time_signal <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          start   <= 1'b0;
        end
      endcase
    end
  end

  assign slot       = slot_q;
  assign slot_valid = valid_q;
  assign state      = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl. Buttons are driven #1 after a rising
// edge and outputs are sampled at the same point. With two sync stages a
// button set after edge E is first sampled at E+1 and acts at E+3.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_run, btn_clr, btn_save, btn_load, btn_slot;
  logic       start, cnt_reset, save_time_signal, load_time_signal;
  logic [1:0] slot;
  logic [2:0] slot_valid;
  logic [1:0] state;

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [4:0] B_RUN  = 5'b10000;
  localparam logic [4:0] B_CLR  = 5'b01000;
  localparam logic [4:0] B_SAVE = 5'b00100;
  localparam logic [4:0] B_LOAD = 5'b00010;
  localparam logic [4:0] B_SLOT = 5'b00001;

  always #5 clk = ~clk;

  stopwatch_ctrl dut (
    .clk(clk), .reset(reset),
    .btn_run(btn_run), .btn_clr(btn_clr), .btn_save(btn_save),
    .btn_load(btn_load), .btn_slot(btn_slot),
    .start(start), .cnt_reset(cnt_reset),
    .save_time_signal(save_time_signal), .load_time_signal(load_time_signal),
    .slot(slot), .slot_valid(slot_valid), .state(state)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] m);
    {btn_run, btn_clr, btn_save, btn_load, btn_slot} = m;
  endtask

  // Press and wait until the resulting output change is visible.
  task automatic press(input logic [4:0] m);
    drive(m);
    tick(3);
  endtask

  task automatic release_all();
    drive(5'b0);
    tick(3);
  endtask

  function automatic logic [2:0] strobes();
    return {cnt_reset, save_time_signal, load_time_signal};
  endfunction

  initial begin
    reset = 1'b1;
    drive(5'b0);
    tick(3);
    chk("rst_state_held", {30'd0, state}, 32'd0);
    chk("rst_strobes_held", {29'd0, strobes()}, 32'd0);
    reset = 1'b0;
    tick(2);
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_start", {31'd0, start}, 32'd0);
    chk("rst_slot", {30'd0, slot}, 32'd0);
    chk("rst_valid", {29'd0, slot_valid}, 32'd0);
    chk("rst_strobes", {29'd0, strobes()}, 32'd0);

    // run: latency check, then hold without repeats
    drive(B_RUN);
    tick(2);
    chk("run_latency_early", {31'd0, start}, 32'd0);
    tick(1);
    chk("run_start", {31'd0, start}, 32'd1);
    chk("run_state", {30'd0, state}, 32'd1);
    tick(3);
    chk("run_hold_state", {30'd0, state}, 32'd1);
    release_all();

    // lap save at slot 0 in RUN, one-cycle strobe while held
    press(B_SAVE);
    chk("save_run_strobe", {29'd0, strobes()}, 32'b010);
    chk("save_run_valid", {29'd0, slot_valid}, 32'b001);
    chk("save_run_start", {31'd0, start}, 32'd1);
    tick(1);
    chk("save_run_oneshot", {29'd0, strobes()}, 32'd0);
    release_all();

    press(B_LOAD);
    chk("load_in_run_ignored", {29'd0, strobes()}, 32'd0);
    chk("load_in_run_state", {30'd0, state}, 32'd1);
    release_all();

    press(B_RUN);
    chk("pause_state", {30'd0, state}, 32'd2);
    chk("pause_start", {31'd0, start}, 32'd0);
    release_all();

    press(B_SLOT);
    chk("slot_1", {30'd0, slot}, 32'd1);
    release_all();
    press(B_SLOT);
    chk("slot_2", {30'd0, slot}, 32'd2);
    release_all();

    press(B_LOAD);
    chk("load_invalid_slot", {29'd0, strobes()}, 32'd0);
    release_all();

    press(B_SAVE);
    chk("save_pause_strobe", {29'd0, strobes()}, 32'b010);
    chk("save_pause_valid", {29'd0, slot_valid}, 32'b101);
    release_all();
    press(B_LOAD);
    chk("load_pause_strobe", {29'd0, strobes()}, 32'b001);
    chk("load_pause_state", {30'd0, state}, 32'd2);
    tick(1);
    chk("load_pause_oneshot", {29'd0, strobes()}, 32'd0);
    release_all();

    press(B_SLOT);
    chk("slot_wrap", {30'd0, slot}, 32'd0);
    release_all();
    press(B_SLOT);
    chk("slot_back_1", {30'd0, slot}, 32'd1);
    release_all();
    press(B_SAVE | B_SLOT);
    chk("save_slot_same_strobe", {29'd0, strobes()}, 32'b010);
    chk("save_slot_same_valid", {29'd0, slot_valid}, 32'b111);
    chk("save_slot_same_slot", {30'd0, slot}, 32'd2);
    release_all();

    press(B_RUN);
    chk("rerun_state", {30'd0, state}, 32'd1);
    release_all();
    press(B_CLR | B_RUN);
    chk("clr_run_strobe", {29'd0, strobes()}, 32'b100);
    chk("clr_run_state", {30'd0, state}, 32'd0);
    chk("clr_run_start", {31'd0, start}, 32'd0);
    chk("clr_keeps_valid", {29'd0, slot_valid}, 32'b111);
    tick(1);
    chk("clr_oneshot", {29'd0, strobes()}, 32'd0);
    release_all();

    press(B_LOAD);
    chk("idle_load_strobe", {29'd0, strobes()}, 32'b001);
    chk("idle_load_state", {30'd0, state}, 32'd2);
    release_all();
    press(B_CLR);
    chk("pause_clr_strobe", {29'd0, strobes()}, 32'b100);
    chk("pause_clr_state", {30'd0, state}, 32'd0);
    release_all();
    press(B_SAVE);
    chk("idle_save_ignored", {29'd0, strobes()}, 32'd0);
    chk("idle_save_state", {30'd0, state}, 32'd0);
    release_all();

    // run held across a reset pulse
    drive(B_RUN);
    tick(1);
    reset = 1'b1;
    tick(2);
    chk("mid_rst_valid", {29'd0, slot_valid}, 32'd0);
    chk("mid_rst_slot", {30'd0, slot}, 32'd0);
    reset = 1'b0;
    tick(4);
    chk("held_run_no_start", {31'd0, start}, 32'd0);
    chk("held_run_state", {30'd0, state}, 32'd0);
    release_all();

    // reset lands on the edge where a save strobe is due
    press(B_RUN);
    chk("pre_rst_run", {30'd0, state}, 32'd1);
    release_all();
    drive(B_SAVE);
    tick(2);
    reset = 1'b1;
    tick(1);
    chk("rst_beats_save_strobe", {29'd0, strobes()}, 32'd0);
    chk("rst_beats_save_valid", {29'd0, slot_valid}, 32'd0);
    chk("rst_beats_save_state", {30'd0, state}, 32'd0);
    reset = 1'b0;
    tick(3);
    chk("post_rst_no_strobe", {29'd0, strobes()}, 32'd0);
    chk("post_rst_valid", {29'd0, slot_valid}, 32'd0);
    release_all();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Button-driven sequencer for the stopwatch counter datapath. Converts five debounced push-button levels into the datapath's control strobes: `start` run level, `cnt_reset` clear pulse, `save_time_signal`/`load_time_signal` one-cycle pulses and the 2-bit `slot` select. It also tracks which memory slots hold a saved time. It sits between the board button debouncers and the counter datapath.

## Interface
Parameters:
- NUM_SLOTS, 3, number of time-memory slots; `slot` wraps at NUM_SLOTS-1.
- SYNC_STAGES, 2, synchronizer depth per button input (minimum 2).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- btn_run  in  1  debounced level; rising edge toggles run/pause.
- btn_clr  in  1  debounced level; rising edge clears the counter.
- btn_save  in  1  debounced level; rising edge saves the time to the current slot.
- btn_load  in  1  debounced level; rising edge loads the current slot.
- btn_slot  in  1  debounced level; rising edge advances the slot.
- start  out  1  counter run enable (level).
- cnt_reset  out  1  one-cycle counter clear.
- save_time_signal  out  1  one-cycle save strobe.
- load_time_signal  out  1  one-cycle load strobe.
- slot  out  2  current slot index, 0..NUM_SLOTS-1.
- slot_valid  out  NUM_SLOTS  bit i set once slot i has been saved.
- state  out  2  IDLE=00, RUN=01, PAUSE=10.

## Operation
- Each button passes through a SYNC_STAGES flop chain, then a rising-edge detector, producing an internal one-cycle event.
- Priority when events coincide: clr > run > save > load. Only the winner acts; the others are dropped.
- The slot event is independent of that priority. A save or load in the same cycle uses the old slot; `slot` updates at the same edge.
- FSM transitions:
  - IDLE: run→RUN. clr→IDLE with `cnt_reset`. load with slot_valid[slot]=1→PAUSE with `load_time_signal`. save is ignored.
  - RUN: run→PAUSE. clr→IDLE with `cnt_reset`. save→`save_time_signal`, stays RUN (lap capture). load is ignored.
  - PAUSE: run→RUN. clr→IDLE with `cnt_reset`. save→`save_time_signal`. load with a valid slot→`load_time_signal`, stays PAUSE.
  - A load to an invalid slot is ignored in every state.
- `start` = 1 exactly when state==RUN.
- `slot_valid[slot]` sets at the same edge as `save_time_signal`. It is cleared only by `reset`; clr does not clear it.
- Slot sequence: 0→1→…→NUM_SLOTS-1→0.

## Timing
- All outputs are registered.
- Latency: a button first sampled high at edge k produces its output change at edge k+SYNC_STAGES.
- Strobes (`cnt_reset`, `save_time_signal`, `load_time_signal`) are high for exactly one cycle per button press. Holding a button produces no repeats.
- `start` falls at the same edge that `cnt_reset` rises when clr is pressed in RUN.
- Values while `reset` is high and after its release:
  - state=IDLE, start=0.
  - All strobes 0, slot=0, slot_valid=0.
  - Synchronizer and edge-history flops = 1, so a button held across reset release generates no event.
- Reset asserted mid-operation, including during a strobe cycle, wins at that edge. No strobe is emitted after a reset edge until a new button edge arrives.

## Structure
- Package `stopwatch_pkg` holds:
  - the state encoding (IDLE/RUN/PAUSE);
  - the NUM_SLOTS default;
  - the SLOT_W=2 constant, shared with the counter datapath.
- Sub-module `btn_sync_edge` (parameter SYNC_STAGES) contains the synchronizer chain plus rising-edge pulse. It is instantiated five times.
- The FSM, slot counter and valid bitmap live in the top level.

## Test plan
- Reset, then pulse btn_run → `start`=1 at edge +2, state=01. Pulse again → `start`=0, state=10. Pulse btn_clr → one-cycle `cnt_reset`, state=00.
- RUN with slot=0: btn_save → `save_time_signal` for 1 cycle, slot_valid=001, `start` stays 1. Then btn_load → no strobe.
- PAUSE, btn_slot twice → slot=2. btn_load → no strobe (slot 2 invalid). btn_save then btn_load → both strobes fire, slot_valid=101.
- Press btn_slot 3 times from slot 0 → slot=0 again (wrap). btn_save and btn_slot rising in the same cycle at slot=1 → save uses slot 1, slot becomes 2.
- btn_clr and btn_run rising in the same cycle in RUN → `cnt_reset` pulses, state=IDLE, `start`=0.
- Hold btn_run high, assert then release `reset` → no `start` after release. Assert `reset` on the cycle a save strobe is due → no strobe, slot_valid=0.
